// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1 UART serializer.
//
// Ports
//   clk       in   system clock, all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   wr_en     in   push strobe, one byte per high cycle
//   wr_data   in   byte to enqueue
//   ovf_clr   in   clears the sticky overflow flag
//   tx        out  registered serial line, idle high
//   full      out  FIFO holds FIFO_DEPTH bytes
//   empty     out  FIFO holds no bytes
//   busy      out  serializer is sending a frame
//   level     out  FIFO occupancy
//   overflow  out  sticky, set when a write arrives while full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic push, pop, baud_last;

    // Status comes straight from registers so a write shows up one cycle later.
    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign level    = cnt_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    assign push      = wr_en & ~full;
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    // Serializer. tx_d is derived from the state being entered so the line
    // changes on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO pointers, occupancy and overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        // A dropped write wins over a clear in the same cycle.
        if (wr_en && full) ovf_d = 1'b1;
        else if (ovf_clr)  ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset, wr_en, ovf_clr;
    logic [7:0] wr_data;
    logic       tx, full, empty, busy, overflow;
    logic [3:0] level;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .ovf_clr(ovf_clr), .tx(tx), .full(full), .empty(empty),
        .busy(busy), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a start bit, then samples each bit mid-period (frame of 40 cycles).
    // Returns while the stop bit is on the line.
    task automatic rx_byte(output logic [7:0] b, output int start);
        int g = 0;
        b = 8'h00;
        while (tx !== 1'b0 && g < 200) begin tick(); g++; end
        nvec++;
        if (tx !== 1'b0) begin
            nerr++;
            $display("FAIL rx_timeout: tx=%b, required start bit 0 within 200 cycles", tx);
            start = -1;
            return;
        end
        start = cyc;
        tick(); tick();
        nvec++;
        if (tx !== 1'b0) begin nerr++; $display("FAIL rx_start_mid: tx=%b required 0", tx); end
        for (int j = 0; j < 8; j++) begin
            repeat (4) tick();
            b[j] = tx;
        end
        repeat (4) tick();
        nvec++;
        if (tx !== 1'b1) begin nerr++; $display("FAIL rx_stop: tx=%b required 1", tx); end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        tick(); tick();
        nvec++; if (tx !== 1'b1)       begin nerr++; $display("FAIL reset_tx: %b req 1", tx); end
        nvec++; if (empty !== 1'b1)    begin nerr++; $display("FAIL reset_empty: %b req 1", empty); end
        nvec++; if (full !== 1'b0)     begin nerr++; $display("FAIL reset_full: %b req 0", full); end
        nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL reset_busy: %b req 0", busy); end
        nvec++; if (level !== 4'd0)    begin nerr++; $display("FAIL reset_level: %0d req 0", level); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf: %b req 0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic       exp;
        d = 8'hA5;
        wr_en = 1'b1; wr_data = d;       // cycle N
        tick();                          // N+1
        wr_en = 1'b0;
        nvec++; if (empty !== 1'b0)  begin nerr++; $display("FAIL single_empty: %b req 0", empty); end
        nvec++; if (level !== 4'd1)  begin nerr++; $display("FAIL single_level: %0d req 1", level); end
        nvec++; if (tx !== 1'b1)     begin nerr++; $display("FAIL single_tx_n1: %b req 1", tx); end
        tick();                          // N+2
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp = 1'b0;
            else if (k < 36) exp = d[(k-4)/4];
            else             exp = 1'b1;
            nvec++;
            if (tx !== exp) begin nerr++; $display("FAIL single_tx cyc N+%0d: %b req %b", k+2, tx, exp); end
            nvec++;
            if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy cyc N+%0d: %b req 1", k+2, busy); end
            tick();
        end
        // N+42
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_idle_busy: %b req 0", busy); end
        nvec++; if (tx !== 1'b1)   begin nerr++; $display("FAIL single_idle_tx: %b req 1", tx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        int s0, s1;
        wr_en = 1'b1; wr_data = 8'h00; tick();
        wr_data = 8'hFF; tick();
        wr_en = 1'b0;
        rx_byte(b0, s0);
        rx_byte(b1, s1);
        nvec++; if (b0 !== 8'h00)  begin nerr++; $display("FAIL b2b_byte0: %h req 00", b0); end
        nvec++; if (b1 !== 8'hFF)  begin nerr++; $display("FAIL b2b_byte1: %h req ff", b1); end
        nvec++; if (s1 - s0 != 40) begin nerr++; $display("FAIL b2b_gap: %0d req 40", s1 - s0); end
        repeat (10) tick();
    endtask

    task automatic test_full_overflow();
        logic [7:0] b;
        int s;
        wr_en = 1'b1; wr_data = 8'h11; tick();     // N+1
        wr_en = 1'b0; tick();                       // N+2, 0x11 starts
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            tick();
        end                                         // N+11
        wr_en = 1'b0;
        nvec++; if (level !== 4'd8)    begin nerr++; $display("FAIL ovf_level: %0d req 8", level); end
        nvec++; if (full !== 1'b1)     begin nerr++; $display("FAIL ovf_full: %b req 1", full); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set: %b req 1", overflow); end
        // clear colliding with another dropped write: stays set
        ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; tick();   // N+12
        wr_en = 1'b0;
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_clr_collide: %b req 1", overflow); end
        tick();                                                   // N+13
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clr: %b req 0", overflow); end
        nvec++; if (level !== 4'd8)    begin nerr++; $display("FAIL ovf_level_hold: %0d req 8", level); end
        repeat (29) tick();                                       // N+42, next start
        for (int i = 0; i < 8; i++) begin
            rx_byte(b, s);
            nvec++;
            if (b !== 8'h20 + 8'(i)) begin nerr++; $display("FAIL ovf_order[%0d]: %h req %h", i, b, 8'h20 + 8'(i)); end
        end
        repeat (10) tick();
    endtask

    task automatic test_wrap();
        int maxlvl = 0;
        fork
            begin
                int i = 0;
                int g = 0;
                while (i < 20 && g < 3000) begin
                    if (level < 4'd6) begin
                        wr_en = 1'b1; wr_data = 8'(i); i++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    tick(); g++;
                    if (int'(level) > maxlvl) maxlvl = int'(level);
                end
                wr_en = 1'b0;
            end
            begin
                logic [7:0] b;
                int s;
                for (int k = 0; k < 20; k++) begin
                    rx_byte(b, s);
                    nvec++;
                    if (b !== 8'(k)) begin nerr++; $display("FAIL wrap_byte[%0d]: %h req %h", k, b, 8'(k)); end
                end
            end
        join
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL wrap_ovf: %b req 0", overflow); end
        nvec++; if (maxlvl > 6)        begin nerr++; $display("FAIL wrap_maxlvl: %0d req <=6", maxlvl); end
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int s;
        for (int i = 0; i < 4; i++) begin           // cycles N..N+3
            wr_en = 1'b1; wr_data = (i == 0) ? 8'h52 : 8'(i);
            tick();
        end
        wr_en = 1'b0;                                // N+4
        repeat (15) tick();                          // N+19, DATA bit 3 of 0x52 = 0
        nvec++; if (tx !== 1'b0)    begin nerr++; $display("FAIL rst_pre_tx: %b req 0", tx); end
        nvec++; if (level !== 4'd3) begin nerr++; $display("FAIL rst_pre_level: %0d req 3", level); end
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();                                      // N+20
        reset = 1'b0; wr_en = 1'b0;
        nvec++; if (tx !== 1'b1)    begin nerr++; $display("FAIL rst_tx: %b req 1", tx); end
        nvec++; if (level !== 4'd0) begin nerr++; $display("FAIL rst_level: %0d req 0", level); end
        nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL rst_busy: %b req 0", busy); end
        tick();
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL rst_ignored_wr: empty=%b req 1", empty); end
        wr_en = 1'b1; wr_data = 8'h3C; tick();
        wr_en = 1'b0;
        rx_byte(b, s);
        nvec++; if (b !== 8'h3C) begin nerr++; $display("FAIL rst_after_byte: %h req 3c", b); end
        repeat (10) tick();
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] b;
        int s;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 9; i++) begin            // cycles N..N+8
            wr_en = 1'b1; wr_data = (i == 0) ? 8'hA0 : 8'hB0 + 8'(i - 1);
            tick();
        end
        wr_en = 1'b0;                                 // N+9
        nvec++; if (level !== 4'd8) begin nerr++; $display("FAIL simpop_fill: %0d req 8", level); end
        repeat (32) tick();                           // N+41, last stop cycle
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL simpop_pre_ovf: %b req 0", overflow); end
        nvec++; if (full !== 1'b1)     begin nerr++; $display("FAIL simpop_pre_full: %b req 1", full); end
        wr_en = 1'b1; wr_data = 8'hCC;
        tick();                                       // N+42
        wr_en = 1'b0;
        nvec++; if (level !== 4'd7)    begin nerr++; $display("FAIL simpop_level: %0d req 7", level); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL simpop_ovf: %b req 1", overflow); end
        nvec++; if (full !== 1'b0)     begin nerr++; $display("FAIL simpop_full: %b req 0", full); end
        nvec++; if (tx !== 1'b0)       begin nerr++; $display("FAIL simpop_start: %b req 0", tx); end
        rx_byte(b, s);
        nvec++; if (b !== 8'hB0)       begin nerr++; $display("FAIL simpop_byte: %h req b0", b); end
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_overflow();
        test_wrap();
        test_reset_mid_frame();
        test_full_simul_pop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
